prog_run_ctrl: RTL and testbench



---
 rtl/prog_run_pkg.sv | 40 ++++
 rtl/run_cycle_ctr.sv | 63 ++++++
 rtl/prog_run_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_prog_run_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_run_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_run_pkg
// Purpose  : Shared types and default constants for the program-run
//            sequencer (prog_run_ctrl) and its cycle counter.
// Contents : state encoding + enum, default CYC_W / RST_CYC / TIMEOUT_CYC,
//            idx_width() helper used to size the program index port.
// Revision : 1.0 - initial release
// ============================================================================
package prog_run_pkg;

  // Default parameter values for prog_run_ctrl
  localparam int DEF_CYC_W       = 16;
  localparam int DEF_RST_CYC     = 2;
  localparam int DEF_TIMEOUT_CYC = 50000;

  // Sequencer state encoding, fixed 3-bit width
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CRST   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_CRST   = S_CRST,
    ST_START  = S_START,
    ST_RUN    = S_RUN,
    ST_REPORT = S_REPORT,
    ST_DONE   = S_DONE
  } state_e;

  // Width of the program index; a single-program build still gets 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : prog_run_pkg
`default_nettype wire

// File: rtl/run_cycle_ctr.sv
`default_nettype none
// ============================================================================
// Module   : run_cycle_ctr
// Purpose  : Saturating up/down counter with zero detect. Counts RUN cycles
//            upward (sticking at all-ones) and, after a reload, counts the
//            core-reset hold period downward (sticking at zero).
// Ports    : clk        - clock, posedge
//            rst        - synchronous active-high reset (count -> 0)
//            i_clr      - clear count to 0 (priority over load/en)
//            i_load     - load i_load_val
//            i_load_val - reload value
//            i_en       - count enable
//            i_down     - 1: count down, 0: count up
//            o_count    - current count
//            o_zero     - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module run_cycle_ctr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      if (i_down) begin
        // Hold at zero so a stray extra enable cannot wrap to all-ones
        if (r_count != '0) begin
          r_count <= r_count - c_ONE;
        end
      end else begin
        // Saturate: a hung program reports all-ones, never a wrapped value
        if (r_count != c_ALL_ONES) begin
          r_count <= r_count + c_ONE;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule : run_cycle_ctr
`default_nettype wire

// File: rtl/prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_run_ctrl
// Purpose  : Host-side sequencer for the processor core. Resets the core,
//            then starts NUM_PROGS programs back to back, measures the RUN
//            cycle count of each and reports it with a one-cycle strobe.
// Options  : `define RUN_TIMEOUT_EN to abort a program that runs for
//            TIMEOUT_CYC cycles without an Ack (sets TimedOut, skips the
//            remaining programs). Undefined: RUN waits for Ack forever.
// Ports    : Clk        - clock, posedge
//            Reset      - synchronous active-high reset
//            Go         - start a sequence (honoured in IDLE/DONE only)
//            CoreAck    - done flag from the core
//            CoreReset  - reset to the core (Reset OR hold period)
//            CoreStart  - one-cycle start pulse to the core
//            ProgIdx    - index of current / last program
//            CycleCount - RUN cycles of the last finished program
//            CountValid - one-cycle strobe qualifying CycleCount/ProgIdx
//            Busy       - sequence in progress
//            Done       - sequence finished (sticky until Go/Reset)
//            TimedOut   - sequence aborted by timeout (sticky until Go/Reset)
// Revision : 1.0 - initial release
// ============================================================================
module prog_run_ctrl
  import prog_run_pkg::*;
#(
  parameter int NUM_PROGS   = 3,
  parameter int CYC_W       = DEF_CYC_W,
  parameter int RST_CYC     = DEF_RST_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Go,
  input  logic                              CoreAck,
  output logic                              CoreReset,
  output logic                              CoreStart,
  output logic [idx_width(NUM_PROGS)-1:0]   ProgIdx,
  output logic [CYC_W-1:0]                  CycleCount,
  output logic                              CountValid,
  output logic                              Busy,
  output logic                              Done,
  output logic                              TimedOut
);

  localparam int                 c_IDX_W     = idx_width(NUM_PROGS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_PROGS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);
  // The hold countdown leaves CRST when it reaches zero, so loading
  // RST_CYC-1 yields exactly RST_CYC cycles of CRST.
  localparam logic [CYC_W-1:0]   c_CRST_LOAD = CYC_W'(RST_CYC - 1);

  state_e               r_state;
  logic [c_IDX_W-1:0]   r_prog_idx;
  logic [CYC_W-1:0]     r_cycle_count;

  logic                 w_ctr_clr;
  logic                 w_ctr_load;
  logic                 w_ctr_en;
  logic                 w_ctr_down;
  logic [CYC_W-1:0]     w_count;
  logic                 w_ctr_zero;
  logic                 w_go_accept;
  logic                 w_ack_ok;
  logic                 w_timeout_hit;
  logic                 w_timed_out;

  // --------------------------------------------------------------------------
  // Shared counter: CRST hold countdown, then RUN cycle measurement
  // --------------------------------------------------------------------------
  run_cycle_ctr #(
    .WIDTH (CYC_W)
  ) u_ctr (
    .clk        (Clk),
    .rst        (Reset),
    .i_clr      (w_ctr_clr),
    .i_load     (w_ctr_load),
    .i_load_val (c_CRST_LOAD),
    .i_en       (w_ctr_en),
    .i_down     (w_ctr_down),
    .o_count    (w_count),
    .o_zero     (w_ctr_zero)
  );

  always_comb begin
    w_ctr_clr  = 1'b0;
    w_ctr_load = 1'b0;
    w_ctr_en   = 1'b0;
    w_ctr_down = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: w_ctr_load = Go;
      ST_CRST: begin
        w_ctr_en   = 1'b1;
        w_ctr_down = 1'b1;
      end
      ST_START: w_ctr_clr = 1'b1;
      ST_RUN:   w_ctr_en  = 1'b1;
      default:  ;
    endcase
  end

  assign w_go_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && Go;

  // Counter is zero only in the first RUN cycle; an Ack there is the stale
  // flag left over from the previous program's halt.
  assign w_ack_ok = (r_state == ST_RUN) && CoreAck && !w_ctr_zero;

  // --------------------------------------------------------------------------
  // Optional hung-program timeout
  // --------------------------------------------------------------------------
`ifdef RUN_TIMEOUT_EN
  localparam logic [CYC_W-1:0] c_TIMEOUT_LAST = CYC_W'(TIMEOUT_CYC - 1);

  logic r_timed_out;

  assign w_timeout_hit = (r_state == ST_RUN) && (w_count == c_TIMEOUT_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_timed_out <= 1'b0;
    end else if (w_go_accept) begin
      r_timed_out <= 1'b0;
    end else if (w_timeout_hit && !w_ack_ok) begin
      // A real Ack in the same cycle wins over the timeout
      r_timed_out <= 1'b1;
    end
  end

  assign w_timed_out = r_timed_out;
`else
  logic [CYC_W-1:0] w_unused_timeout;

  assign w_unused_timeout = CYC_W'(TIMEOUT_CYC);
  assign w_timeout_hit    = 1'b0;
  assign w_timed_out      = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_prog_idx    <= '0;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (Go) begin
            r_prog_idx <= '0;
            r_state    <= ST_CRST;
          end
        end

        ST_CRST: begin
          if (w_ctr_zero) begin
            r_state <= ST_START;
          end
        end

        ST_START: begin
          r_state <= ST_RUN;
        end

        ST_RUN: begin
          if (w_ack_ok || w_timeout_hit) begin
            r_cycle_count <= w_count;
            r_state       <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          // Programs run back to back with no core reset in between
          if ((r_prog_idx == c_LAST_IDX) || w_timed_out) begin
            r_state <= ST_DONE;
          end else begin
            r_prog_idx <= r_prog_idx + c_IDX_ONE;
            r_state    <= ST_START;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Combinational so the core is reset in the same cycles as this block
  assign CoreReset  = Reset | (r_state == ST_CRST);
  assign CoreStart  = (r_state == ST_START);
  assign CountValid = (r_state == ST_REPORT);
  assign Busy       = (r_state == ST_CRST)  || (r_state == ST_START) ||
                      (r_state == ST_RUN)   || (r_state == ST_REPORT);
  assign Done       = (r_state == ST_DONE);
  assign TimedOut   = w_timed_out;
  assign ProgIdx    = r_prog_idx;
  assign CycleCount = r_cycle_count;

endmodule : prog_run_ctrl
`default_nettype wire

// File: tb/tb_prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_run_ctrl
// Purpose  : Directed self-checking bench for prog_run_ctrl. A 3-program
//            instance is exercised with a cycle-accurate core Ack model; a
//            1-program, 4-bit-counter instance covers counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic        ack = 1'b0;
  logic        core_rst, core_start, cnt_valid, busy, done, timed_out;
  logic [1:0]  prog_idx;
  logic [15:0] cyc_cnt;

  logic        go2  = 1'b0;
  logic        ack2 = 1'b0;
  logic        core_rst2, core_start2, cnt_valid2, busy2, done2, timed_out2;
  logic [0:0]  prog_idx2;
  logic [3:0]  cyc_cnt2;

  always #5 clk = ~clk;

  prog_run_ctrl #(
    .NUM_PROGS (3), .CYC_W (16), .RST_CYC (2), .TIMEOUT_CYC (100)
  ) dut (
    .Clk (clk), .Reset (rst), .Go (go), .CoreAck (ack),
    .CoreReset (core_rst), .CoreStart (core_start), .ProgIdx (prog_idx),
    .CycleCount (cyc_cnt), .CountValid (cnt_valid), .Busy (busy),
    .Done (done), .TimedOut (timed_out)
  );

  prog_run_ctrl #(
    .NUM_PROGS (1), .CYC_W (4), .RST_CYC (1), .TIMEOUT_CYC (16)
  ) dut2 (
    .Clk (clk), .Reset (rst), .Go (go2), .CoreAck (ack2),
    .CoreReset (core_rst2), .CoreStart (core_start2), .ProgIdx (prog_idx2),
    .CycleCount (cyc_cnt2), .CountValid (cnt_valid2), .Busy (busy2),
    .Done (done2), .TimedOut (timed_out2)
  );

  int n_vec = 0;
  int n_err = 0;

  // core model configuration
  int cfg_dly[3];
  bit cfg_stale;
  bit cfg_go_in_run;
  int cfg_abort_start;
  int cfg_abort_c;

  // observations from the last run_seq
  int n_start, n_cv, n_crst, first_start, done_at1;
  bit saw_done;
  int rec_idx[4], rec_cnt[4], rec_to[4], rec_cyc[4], start_cyc[4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulses Go, then steps up to 'budget' cycles acting as the core: the Ack
  // for program k is driven in the RUN cycle whose counter equals cfg_dly[k].
  // c tracks the DUT counter of the current cycle (-1 = START cycle).
  task automatic run_seq(input int budget);
    int c;
    int n;
    n_start = 0; n_cv = 0; n_crst = 0; first_start = -1; done_at1 = -1;
    saw_done = 1'b0; c = -100;
    go = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      tick;
      go = 1'b0;
      if (cyc == 1) done_at1 = int'(done);
      if (core_rst) n_crst++;
      if (cnt_valid) begin
        if (n_cv < 4) begin
          rec_idx[n_cv] = int'(prog_idx);
          rec_cnt[n_cv] = int'(cyc_cnt);
          rec_to[n_cv]  = int'(timed_out);
          rec_cyc[n_cv] = cyc;
        end
        n_cv++;
      end
      if (core_start) begin
        if (n_start < 4) start_cyc[n_start] = cyc;
        if (first_start < 0) first_start = cyc;
        n_start++;
        c = -1;
      end else if (c > -100) begin
        c++;
      end
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (cfg_abort_start != 0 && n_start == cfg_abort_start && c == cfg_abort_c) break;
      n   = (n_start >= 1 && n_start <= 3) ? cfg_dly[n_start-1] : -1;
      ack = ((c >= 1) && (c == n)) || (cfg_stale && (c == -1 || c == 0));
      go  = cfg_go_in_run && (n_start == 1) && (c == 3);
    end
    ack = 1'b0;
    go  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    n_vec++; if (core_rst !== 1'b1) begin n_err++; $display("FAIL rst_core_reset: got %b want 1", core_rst); end
    n_vec++; if ({core_start, cnt_valid, busy, done, timed_out} !== 5'b0) begin n_err++; $display("FAIL rst_flags: got %b want 00000", {core_start, cnt_valid, busy, done, timed_out}); end
    n_vec++; if (prog_idx !== 2'd0 || cyc_cnt !== 16'd0) begin n_err++; $display("FAIL rst_idx_cnt: got %0d/%0d want 0/0", prog_idx, cyc_cnt); end
    n_vec++; if (core_rst2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) begin n_err++; $display("FAIL rst_dut2: got %b%b%b want 100", core_rst2, busy2, done2); end
    tick;
    tick;
    rst = 1'b0;
    tick;
    tick;
    n_vec++; if (core_rst !== 1'b0) begin n_err++; $display("FAIL idle_core_reset: got %b want 0", core_rst); end
    n_vec++; if ({core_start, busy, done, cnt_valid} !== 4'b0) begin n_err++; $display("FAIL idle_flags: got %b want 0000", {core_start, busy, done, cnt_valid}); end
  endtask

  task automatic test_sequence;
    cfg_dly = '{10, 20, 5}; cfg_stale = 0; cfg_go_in_run = 0; cfg_abort_start = 0; cfg_abort_c = 0;
    run_seq(300);
    n_vec++; if (n_crst !== 2) begin n_err++; $display("FAIL seq_crst_cycles: got %0d want 2", n_crst); end
    n_vec++; if (first_start !== 3) begin n_err++; $display("FAIL seq_go_to_start: got %0d want 3", first_start); end
    n_vec++; if (n_start !== 3 || n_cv !== 3) begin n_err++; $display("FAIL seq_pulses: got starts %0d cv %0d want 3 3", n_start, n_cv); end
    n_vec++; if (rec_idx[0] !== 0 || rec_cnt[0] !== 10) begin n_err++; $display("FAIL seq_prog0: got (%0d,%0d) want (0,10)", rec_idx[0], rec_cnt[0]); end
    n_vec++; if (rec_idx[1] !== 1 || rec_cnt[1] !== 20) begin n_err++; $display("FAIL seq_prog1: got (%0d,%0d) want (1,20)", rec_idx[1], rec_cnt[1]); end
    n_vec++; if (rec_idx[2] !== 2 || rec_cnt[2] !== 5) begin n_err++; $display("FAIL seq_prog2: got (%0d,%0d) want (2,5)", rec_idx[2], rec_cnt[2]); end
    n_vec++; if (rec_cyc[0] !== start_cyc[0] + 12) begin n_err++; $display("FAIL seq_ack_latency: got %0d want %0d", rec_cyc[0], start_cyc[0] + 12); end
    n_vec++; if (!saw_done || done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL seq_done: got done %b busy %b want 1 0", done, busy); end
    n_vec++; if (prog_idx !== 2'd2 || timed_out !== 1'b0) begin n_err++; $display("FAIL seq_final: got idx %0d to %b want 2 0", prog_idx, timed_out); end
  endtask

  task automatic test_back_to_back;
    n_vec++; if (start_cyc[1] !== rec_cyc[0] + 1) begin n_err++; $display("FAIL b2b_start1: got %0d want %0d", start_cyc[1], rec_cyc[0] + 1); end
    n_vec++; if (start_cyc[2] !== rec_cyc[1] + 1) begin n_err++; $display("FAIL b2b_start2: got %0d want %0d", start_cyc[2], rec_cyc[1] + 1); end
  endtask

  task automatic test_stale_ack;
    // Starts from DONE, so this also covers Go restarting a finished sequence
    cfg_dly = '{7, 7, 7}; cfg_stale = 1;
    run_seq(300);
    cfg_stale = 0;
    n_vec++; if (done_at1 !== 0) begin n_err++; $display("FAIL go_in_done_clears: got %0d want 0", done_at1); end
    n_vec++; if (n_crst !== 2) begin n_err++; $display("FAIL go_in_done_crst: got %0d want 2", n_crst); end
    n_vec++; if (n_cv !== 3 || rec_cnt[0] !== 7 || rec_cnt[1] !== 7 || rec_cnt[2] !== 7) begin n_err++; $display("FAIL stale_ack_counts: got n %0d %0d %0d %0d want 3 7 7 7", n_cv, rec_cnt[0], rec_cnt[1], rec_cnt[2]); end
    n_vec++; if (!saw_done) begin n_err++; $display("FAIL stale_ack_done: got 0 want 1"); end
  endtask

  task automatic test_go_in_run;
    cfg_dly = '{4, 6, 8}; cfg_go_in_run = 1;
    run_seq(300);
    cfg_go_in_run = 0;
    n_vec++; if (n_crst !== 2 || n_start !== 3) begin n_err++; $display("FAIL go_run_ignored: got crst %0d starts %0d want 2 3", n_crst, n_start); end
    n_vec++; if (rec_cnt[0] !== 4 || rec_cnt[1] !== 6 || rec_cnt[2] !== 8 || rec_idx[2] !== 2) begin n_err++; $display("FAIL go_run_counts: got %0d %0d %0d idx %0d want 4 6 8 idx 2", rec_cnt[0], rec_cnt[1], rec_cnt[2], rec_idx[2]); end
  endtask

  task automatic test_reset_mid_run;
    cfg_dly = '{10, 20, 5}; cfg_abort_start = 2; cfg_abort_c = 5;
    run_seq(300);
    cfg_abort_start = 0;
    n_vec++; if (busy !== 1'b1 || prog_idx !== 2'd1) begin n_err++; $display("FAIL midrun_pre: got busy %b idx %0d want 1 1", busy, prog_idx); end
    rst = 1'b1;
    tick;
    n_vec++; if (busy !== 1'b0 || prog_idx !== 2'd0 || core_rst !== 1'b1) begin n_err++; $display("FAIL midrun_reset: got busy %b idx %0d crst %b want 0 0 1", busy, prog_idx, core_rst); end
    n_vec++; if (cyc_cnt !== 16'd0 || {core_start, cnt_valid, done} !== 3'b0) begin n_err++; $display("FAIL midrun_reset_clr: got cnt %0d flags %b want 0 000", cyc_cnt, {core_start, cnt_valid, done}); end
    rst = 1'b0;
    tick;
    n_vec++; if (core_rst !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrun_release: got crst %b busy %b want 0 0", core_rst, busy); end
    cfg_dly = '{3, 3, 3};
    run_seq(300);
    n_vec++; if (n_cv !== 3 || rec_idx[0] !== 0 || rec_cnt[0] !== 3 || !saw_done) begin n_err++; $display("FAIL midrun_restart: got n %0d idx %0d cnt %0d done %b want 3 0 3 1", n_cv, rec_idx[0], rec_cnt[0], saw_done); end
  endtask

  task automatic test_timeout;
    cfg_dly = '{1000, 1000, 1000};
`ifdef RUN_TIMEOUT_EN
    run_seq(300);
    n_vec++; if (n_cv !== 1 || rec_cnt[0] !== 99 || rec_to[0] !== 1) begin n_err++; $display("FAIL timeout_report: got n %0d cnt %0d to %0d want 1 99 1", n_cv, rec_cnt[0], rec_to[0]); end
    n_vec++; if (!saw_done || prog_idx !== 2'd0 || timed_out !== 1'b1) begin n_err++; $display("FAIL timeout_done: got done %b idx %0d to %b want 1 0 1", saw_done, prog_idx, timed_out); end
    for (int i = 0; i < 5; i++) begin
      tick;
      if (core_start) n_start++;
    end
    n_vec++; if (n_start !== 1) begin n_err++; $display("FAIL timeout_no_more_start: got %0d want 1", n_start); end
`else
    run_seq(150);
    n_vec++; if (n_cv !== 0 || saw_done || busy !== 1'b1) begin n_err++; $display("FAIL noto_stays_run: got cv %0d done %b busy %b want 0 0 1", n_cv, saw_done, busy); end
    n_vec++; if (cyc_cnt !== 16'd3 || timed_out !== 1'b0) begin n_err++; $display("FAIL noto_count: got cnt %0d to %b want 3 0", cyc_cnt, timed_out); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
`endif
    // A fresh sequence clears any previous timeout
    cfg_dly = '{2, 4, 6};
    run_seq(300);
    n_vec++; if (n_cv !== 3 || rec_to[0] !== 0 || rec_cnt[2] !== 6 || timed_out !== 1'b0) begin n_err++; $display("FAIL after_timeout_seq: got n %0d to %0d cnt %0d want 3 0 6", n_cv, rec_to[0], rec_cnt[2]); end
  endtask

  task automatic test_saturation;
    int c, n, first, cvn, cc, idx, to;
    bit saw;
    c = -100; n = 0; first = -1; cvn = 0; cc = -1; idx = -1; to = -1; saw = 0;
    go2 = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick;
      go2 = 1'b0;
      if (core_start2) begin
        n++;
        if (first < 0) first = cyc;
        c = -1;
      end else if (c > -100) begin
        c++;
      end
      if (cnt_valid2) begin
        cvn++; cc = int'(cyc_cnt2); idx = int'(prog_idx2); to = int'(timed_out2);
      end
      if (done2) begin
        saw = 1'b1;
        break;
      end
      ack2 = (c == 20);
    end
    ack2 = 1'b0;
    n_vec++; if (first !== 2 || n !== 1) begin n_err++; $display("FAIL sat_start: got first %0d n %0d want 2 1", first, n); end
    n_vec++; if (cvn !== 1 || cc !== 15 || idx !== 0) begin n_err++; $display("FAIL sat_count: got n %0d cnt %0d idx %0d want 1 15 0", cvn, cc, idx); end
    n_vec++; if (!saw || busy2 !== 1'b0) begin n_err++; $display("FAIL sat_single_done: got done %b busy %b want 1 0", saw, busy2); end
`ifdef RUN_TIMEOUT_EN
    n_vec++; if (to !== 1) begin n_err++; $display("FAIL sat_timedout: got %0d want 1", to); end
`else
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL sat_timedout: got %0d want 0", to); end
`endif
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_back_to_back;
    test_stale_ack;
    test_go_in_run;
    test_reset_mid_run;
    test_timeout;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_prog_run_ctrl
`default_nettype wire
